// File: rtl/tcm_pkg.sv
// Shared sizing constants and lane helpers for the tightly-coupled memory.
package tcm_pkg;

  localparam int MEM_BYTES_DEF = 131072;
  localparam int TAG_W         = 11;
  localparam int LANE_W        = 3;
  localparam int WORD_IDX_W    = $clog2(MEM_BYTES_DEF) - LANE_W;

  // Place the 4 store strobes into the low or high half of a 64-bit word.
  function automatic logic [7:0] lane_be(input logic [3:0] wr, input logic hi);
    logic [7:0] be;
    if (hi) begin
      be = {wr, 4'b0000};
    end else begin
      be = {4'b0000, wr};
    end
    return be;
  endfunction

endpackage

// File: rtl/tcm_memory_ram.sv
// True dual-port 64-bit RAM: port A read-only, port B read/write with byte enables.
// Both ports return the contents as they were before any write on the same edge.
module tcm_memory_ram
  import tcm_pkg::*;
#(
  parameter int DEPTH = MEM_BYTES_DEF / 8,
  parameter int AW    = WORD_IDX_W
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          a_en_i,
  input  logic [AW-1:0] a_addr_i,
  output logic [63:0]   a_rdata_o,
  input  logic          b_en_i,
  input  logic [AW-1:0] b_addr_i,
  input  logic [7:0]    b_be_i,
  input  logic [63:0]   b_wdata_i,
  output logic [63:0]   b_rdata_o
);

  logic [63:0] r_mem [DEPTH];
  logic [63:0] r_a_q;
  logic [63:0] r_b_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_a_q <= 64'd0;
    end else if (a_en_i) begin
      r_a_q <= r_mem[a_addr_i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_b_q <= 64'd0;
    end else if (b_en_i) begin
      r_b_q <= r_mem[b_addr_i];
    end
  end

  // Storage is deliberately not reset so preloaded images survive rst_i.
  always_ff @(posedge clk_i) begin
    if (b_en_i) begin
      for (int k = 0; k < 8; k++) begin
        if (b_be_i[k]) begin
          r_mem[b_addr_i][k*8 +: 8] <= b_wdata_i[k*8 +: 8];
        end
      end
    end
  end

  assign a_rdata_o = r_a_q;
  assign b_rdata_o = r_b_q;

  task automatic backdoor_write(input logic [AW-1:0] idx, input logic [2:0] lane,
                                input logic [7:0] data);
    r_mem[idx][{lane, 3'b000} +: 8] <= data;
  endtask

endmodule

// File: rtl/tcm_memory.sv
// 128 KB tightly-coupled memory: 64-bit fetch port and 32-bit data port,
// every request accepted at once and answered on the following edge.
module tcm_memory
  import tcm_pkg::*;
#(
  parameter int MEM_BYTES = MEM_BYTES_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              mem_i_rd_i,
  input  logic              mem_i_flush_i,
  input  logic              mem_i_invalidate_i,
  input  logic [31:0]       mem_i_pc_i,
  output logic              mem_i_accept_o,
  output logic              mem_i_valid_o,
  output logic              mem_i_error_o,
  output logic [63:0]       mem_i_inst_o,
  input  logic [31:0]       mem_d_addr_i,
  input  logic [31:0]       mem_d_data_wr_i,
  input  logic              mem_d_rd_i,
  input  logic [3:0]        mem_d_wr_i,
  input  logic              mem_d_cacheable_i,
  input  logic [TAG_W-1:0]  mem_d_req_tag_i,
  input  logic              mem_d_invalidate_i,
  input  logic              mem_d_writeback_i,
  input  logic              mem_d_flush_i,
  output logic [31:0]       mem_d_data_rd_o,
  output logic              mem_d_accept_o,
  output logic              mem_d_ack_o,
  output logic              mem_d_error_o,
  output logic [TAG_W-1:0]  mem_d_resp_tag_o
);

  localparam int ADDR_HI = $clog2(MEM_BYTES) - 1;
  localparam int AW      = $clog2(MEM_BYTES) - 3;
  localparam int DEPTH   = MEM_BYTES / 8;

  logic             w_fetch_req;
  logic             w_d_req;
  logic [7:0]       w_be;
  logic [63:0]      w_a_q;
  logic [63:0]      w_b_q;
  logic             w_unused;
  logic             r_i_valid;
  logic             r_d_ack;
  logic [TAG_W-1:0] r_resp_tag;
  logic             r_lane_hi;

  // Requests that arrive while rst_i is high are dropped entirely.
  assign w_fetch_req = mem_i_rd_i & ~rst_i;
  assign w_d_req     = (mem_d_rd_i | (|mem_d_wr_i) | mem_d_invalidate_i |
                        mem_d_writeback_i | mem_d_flush_i) & ~rst_i;
  assign w_be        = lane_be(mem_d_wr_i, mem_d_addr_i[2]);

  tcm_memory_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .a_en_i    (w_fetch_req),
    .a_addr_i  (mem_i_pc_i[ADDR_HI:3]),
    .a_rdata_o (w_a_q),
    .b_en_i    (w_d_req),
    .b_addr_i  (mem_d_addr_i[ADDR_HI:3]),
    .b_be_i    (w_be),
    .b_wdata_i ({mem_d_data_wr_i, mem_d_data_wr_i}),
    .b_rdata_o (w_b_q)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_i_valid  <= 1'b0;
      r_d_ack    <= 1'b0;
      r_resp_tag <= {TAG_W{1'b0}};
      r_lane_hi  <= 1'b0;
    end else begin
      r_i_valid <= w_fetch_req;
      r_d_ack   <= w_d_req;
      if (w_d_req) begin
        r_resp_tag <= mem_d_req_tag_i;
        r_lane_hi  <= mem_d_addr_i[2];
      end
    end
  end

  assign mem_i_accept_o   = 1'b1;
  assign mem_i_error_o    = 1'b0;
  assign mem_i_valid_o    = r_i_valid;
  assign mem_i_inst_o     = w_a_q;
  assign mem_d_accept_o   = 1'b1;
  assign mem_d_error_o    = 1'b0;
  assign mem_d_ack_o      = r_d_ack;
  assign mem_d_resp_tag_o = r_resp_tag;
  assign mem_d_data_rd_o  = r_lane_hi ? w_b_q[63:32] : w_b_q[31:0];

  assign w_unused = ^{mem_i_pc_i[31:ADDR_HI+1], mem_i_pc_i[2:0],
                      mem_d_addr_i[31:ADDR_HI+1], mem_d_addr_i[1:0],
                      mem_d_cacheable_i, mem_i_flush_i, mem_i_invalidate_i};

  // Zero-time byte preload for simulation images; addresses wrap modulo MEM_BYTES.
  task automatic write(input logic [31:0] addr, input logic [7:0] data);
    u_ram.backdoor_write(addr[ADDR_HI:3], addr[2:0], data);
  endtask

endmodule

// File: tb/tb_tcm_memory.sv
// Randomised bench for tcm_memory against a byte-array reference model.
module tb_tcm_memory;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_rd = 1'b0, i_flush = 1'b0, i_inval = 1'b0;
  logic [31:0] i_pc = 32'd0;
  logic        i_accept, i_valid, i_error;
  logic [63:0] i_inst;
  logic [31:0] d_addr = 32'd0, d_wdata = 32'd0;
  logic        d_rd = 1'b0, d_cache = 1'b0, d_inval = 1'b0, d_wb = 1'b0, d_flush = 1'b0;
  logic [3:0]  d_wr = 4'd0;
  logic [10:0] d_tag = 11'd0;
  logic [31:0] d_rdata;
  logic        d_accept, d_ack, d_error;
  logic [10:0] d_rtag;

  int total = 0;
  int bad   = 0;

  logic [7:0]  m [0:131071];
  logic        exp_rst = 1'b1, exp_valid = 1'b0, exp_ack = 1'b0, exp_chk_data = 1'b0;
  logic [63:0] exp_inst = 64'd0;
  logic [31:0] exp_data = 32'd0;
  logic [10:0] exp_tag = 11'd0;

  tcm_memory dut (
    .clk_i(clk), .rst_i(rst),
    .mem_i_rd_i(i_rd), .mem_i_flush_i(i_flush), .mem_i_invalidate_i(i_inval),
    .mem_i_pc_i(i_pc), .mem_i_accept_o(i_accept), .mem_i_valid_o(i_valid),
    .mem_i_error_o(i_error), .mem_i_inst_o(i_inst),
    .mem_d_addr_i(d_addr), .mem_d_data_wr_i(d_wdata), .mem_d_rd_i(d_rd),
    .mem_d_wr_i(d_wr), .mem_d_cacheable_i(d_cache), .mem_d_req_tag_i(d_tag),
    .mem_d_invalidate_i(d_inval), .mem_d_writeback_i(d_wb), .mem_d_flush_i(d_flush),
    .mem_d_data_rd_o(d_rdata), .mem_d_accept_o(d_accept), .mem_d_ack_o(d_ack),
    .mem_d_error_o(d_error), .mem_d_resp_tag_o(d_rtag)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [63:0] model_fetch(input logic [31:0] pc);
    logic [63:0] r;
    int base = int'(pc % 32'd131072) & ~7;
    for (int k = 0; k < 8; k++) r[k*8 +: 8] = m[base + k];
    return r;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a);
    logic [31:0] r;
    int base = int'(a % 32'd131072) & ~3;
    for (int k = 0; k < 4; k++) r[k*8 +: 8] = m[base + k];
    return r;
  endfunction

  task automatic bd(input logic [31:0] a, input logic [7:0] v);
    dut.write(a, v);
    m[int'(a % 32'd131072)] = v;
  endtask

  // Compute the expected response to the current inputs, update the model, advance one cycle.
  task automatic cyc();
    if (rst) begin
      exp_rst = 1'b1; exp_valid = 1'b0; exp_ack = 1'b0; exp_chk_data = 1'b0;
    end else begin
      exp_rst      = 1'b0;
      exp_valid    = i_rd;
      exp_inst     = model_fetch(i_pc);
      exp_ack      = d_rd | (|d_wr) | d_inval | d_wb | d_flush;
      exp_tag      = d_tag;
      exp_chk_data = d_rd;
      exp_data     = model_load(d_addr);
      for (int k = 0; k < 4; k++)
        if (d_wr[k]) m[(int'(d_addr % 32'd131072) & ~3) + k] = d_wdata[k*8 +: 8];
    end
    @(negedge clk);
  endtask

  task automatic idle();
    i_rd = 1'b0; i_flush = 1'b0; i_inval = 1'b0;
    d_rd = 1'b0; d_wr = 4'd0; d_inval = 1'b0; d_wb = 1'b0; d_flush = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    return ($urandom & 32'hFFFE_0000) | 32'($urandom_range(0, 4095));
  endfunction

  always @(posedge clk) begin
    #1;
    check("const", {i_accept, d_accept, i_error, d_error}, 64'({1'b1, 1'b1, 1'b0, 1'b0}));
    check("i_valid", 64'(i_valid), 64'(exp_valid));
    check("d_ack", 64'(d_ack), 64'(exp_ack));
    if (exp_rst) begin
      check("rst_tag", 64'(d_rtag), 64'd0);
      check("rst_inst", i_inst, 64'd0);
      check("rst_data", 64'(d_rdata), 64'd0);
    end else begin
      if (exp_valid) check("inst", i_inst, exp_inst);
      if (exp_ack) check("tag", 64'(d_rtag), 64'(exp_tag));
      if (exp_chk_data) check("ld_data", 64'(d_rdata), 64'(exp_data));
    end
  end

  initial begin
    int acks;
    logic [7:0] pre [8];
    pre[0] = 8'h13; pre[1] = 8'h00; pre[2] = 8'h00; pre[3] = 8'h00;
    pre[4] = 8'h93; pre[5] = 8'h00; pre[6] = 8'h10; pre[7] = 8'h00;
    for (int i = 0; i < 4096; i++) bd(32'(i), 8'h00);
    for (int i = 0; i < 8; i++) bd(32'(i), pre[i]);
    cyc(); cyc();
    rst = 1'b0;

    i_rd = 1'b1; i_pc = 32'h8000_0000;
    cyc();
    check("lit_fetch0", i_inst, 64'h0010_0093_0000_0013);
    idle();

    d_addr = 32'h8000_0104; d_wdata = 32'hDEAD_BEEF; d_wr = 4'b0110; d_tag = 11'd5;
    cyc();
    check("lit_st_tag", 64'(d_rtag), 64'd5);
    idle(); d_rd = 1'b1; d_tag = 11'd6;
    cyc();
    check("lit_ld_tag", 64'(d_rtag), 64'd6);
    check("lit_ld_data", 64'(d_rdata), 64'h00AD_BE00);
    idle();

    d_addr = 32'h10; d_wdata = 32'h1122_3344; d_wr = 4'hF; d_tag = 11'd7;
    i_rd = 1'b1; i_pc = 32'h10;
    cyc();
    check("lit_coll_old", 64'(i_inst[31:0]), 64'd0);
    idle(); i_rd = 1'b1;
    cyc();
    check("lit_coll_new", 64'(i_inst[31:0]), 64'h1122_3344);
    idle();

    d_rd = 1'b1; d_addr = 32'h8002_0000; d_tag = 11'd9;
    cyc();
    check("lit_wrap", 64'(d_rdata), 64'h0000_0013);
    idle();

    rst = 1'b1; i_rd = 1'b1; i_pc = 32'h0; d_rd = 1'b1; d_addr = 32'h4; d_tag = 11'd3;
    cyc();
    check("lit_rst_valid", 64'({i_valid, d_ack}), 64'd0);
    cyc();
    check("lit_rst_out", {i_inst[31:0], d_rdata}, 64'd0);
    rst = 1'b0; idle(); i_rd = 1'b1; i_pc = 32'h0;
    cyc();
    check("lit_retain", i_inst, 64'h0010_0093_0000_0013);
    idle();

    acks = 0;
    for (int i = 0; i < 16; i++) begin
      d_rd = 1'b1; d_addr = rand_addr(); d_tag = 11'(100 + i);
      cyc();
      if (d_ack && d_rtag == 11'(100 + i)) acks++;
    end
    check("b2b_acks", 64'(acks), 64'd16);
    idle();

    for (int i = 0; i < 400; i++) begin
      rst     = ($urandom_range(0, 99) == 0);
      i_rd    = $urandom_range(0, 1) == 1;
      i_flush = $urandom_range(0, 7) == 0;
      i_inval = $urandom_range(0, 7) == 0;
      i_pc    = rand_addr();
      d_addr  = rand_addr();
      d_wdata = $urandom;
      d_rd    = $urandom_range(0, 2) == 0;
      d_wr    = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'd0;
      d_inval = $urandom_range(0, 15) == 0;
      d_wb    = $urandom_range(0, 15) == 0;
      d_flush = $urandom_range(0, 15) == 0;
      d_cache = 1'($urandom);
      d_tag   = 11'($urandom);
      cyc();
    end
    rst = 1'b0; idle();
    cyc(); cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
